// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data-memory geometry, arbiter FSM states and
// requester port encoding.
package pipeline_pkg;

  localparam int ANCHO_DATOS_MEM = 32;
  localparam int ANCHO_DIR_MEM   = 10;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    ACCESO   = 2'd1,
    FIN      = 2'd2
  } estado_arb_t;

  typedef enum logic {
    P = 1'b0,
    D = 1'b1
  } puerto_t;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way request selector: round-robin on ties, or fixed priority to the
// MEM-stage port. Purely combinational; grant bit 0 = P, bit 1 = D.
module arbitro_rr2
  import pipeline_pkg::*;
#(
  parameter int PRIORIDAD_FIJA = 0
) (
  input  logic       p_req,
  input  logic       d_req,
  input  puerto_t    ultimo,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (p_req && d_req) begin
      // On a tie the port that was not served last goes first.
      if ((PRIORIDAD_FIJA != 0) || (ultimo == D)) grant = 2'b01;
      else                                         grant = 2'b10;
    end else if (p_req) begin
      grant = 2'b01;
    end else if (d_req) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// Arbiter and access sequencer sharing the single-port data memory between
// the MEM stage (p_) and the debug/loader port (d_), one access per 3 cycles.
module arbitro_memoria_datos
  import pipeline_pkg::*;
#(
  parameter int ANCHO_DATOS    = ANCHO_DATOS_MEM,
  parameter int ANCHO_DIR      = ANCHO_DIR_MEM,
  parameter int PRIORIDAD_FIJA = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p_req,
  input  logic                   p_we,
  input  logic [ANCHO_DIR-1:0]   p_direccion,
  input  logic [ANCHO_DATOS-1:0] p_din,
  output logic                   p_ack,
  output logic [ANCHO_DATOS-1:0] p_rdata,
  output logic                   p_stall,
  input  logic                   d_req,
  input  logic                   d_we,
  input  logic [ANCHO_DIR-1:0]   d_direccion,
  input  logic [ANCHO_DATOS-1:0] d_din,
  output logic                   d_ack,
  output logic [ANCHO_DATOS-1:0] d_rdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [ANCHO_DIR-1:0]   mem_direccion,
  output logic [ANCHO_DATOS-1:0] mem_din,
  input  logic [ANCHO_DATOS-1:0] mem_dout
);

  estado_arb_t            state_q, state_d;
  puerto_t                ultimo_q, ultimo_d;
  puerto_t                ganador_q, ganador_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [ANCHO_DIR-1:0]   mem_direccion_q, mem_direccion_d;
  logic [ANCHO_DATOS-1:0] mem_din_q, mem_din_d;
  logic                   p_ack_q, p_ack_d;
  logic                   d_ack_q, d_ack_d;
  logic [ANCHO_DATOS-1:0] p_rdata_q, p_rdata_d;
  logic [ANCHO_DATOS-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]             grant;
  logic                   we_sel;

  arbitro_rr2 #(
    .PRIORIDAD_FIJA(PRIORIDAD_FIJA)
  ) u_arbitro_rr2 (
    .p_req (p_req),
    .d_req (d_req),
    .ultimo(ultimo_q),
    .grant (grant)
  );

  always_comb begin
    state_d         = state_q;
    ultimo_d        = ultimo_q;
    ganador_d       = ganador_q;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_direccion_d = mem_direccion_q;
    mem_din_d       = mem_din_q;
    p_ack_d         = 1'b0;
    d_ack_d         = 1'b0;
    p_rdata_d       = p_rdata_q;
    d_rdata_d       = d_rdata_q;
    we_sel          = 1'b0;
    unique case (state_q)
      INACTIVO: begin
        if (grant != 2'b00) begin
          ganador_d       = grant[1] ? D : P;
          ultimo_d        = grant[1] ? D : P;
          we_sel          = grant[1] ? d_we : p_we;
          mem_read_d      = ~we_sel;
          mem_write_d     = we_sel;
          mem_direccion_d = grant[1] ? d_direccion : p_direccion;
          mem_din_d       = grant[1] ? d_din : p_din;
          state_d         = ACCESO;
        end
      end
      ACCESO: begin
        // mem_dout was produced on the falling edge of this cycle.
        if (ganador_q == P) begin
          p_ack_d = 1'b1;
          if (mem_read_q) p_rdata_d = mem_dout;
        end else begin
          d_ack_d = 1'b1;
          if (mem_read_q) d_rdata_d = mem_dout;
        end
        state_d = FIN;
      end
      FIN: begin
        // Requests are ignored here so a port dropping req on ack is not re-served.
        state_d = INACTIVO;
      end
      default: state_d = INACTIVO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= INACTIVO;
      ultimo_q        <= D;
      ganador_q       <= P;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_direccion_q <= '0;
      mem_din_q       <= '0;
      p_ack_q         <= 1'b0;
      d_ack_q         <= 1'b0;
      p_rdata_q       <= '0;
      d_rdata_q       <= '0;
    end else begin
      state_q         <= state_d;
      ultimo_q        <= ultimo_d;
      ganador_q       <= ganador_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_direccion_q <= mem_direccion_d;
      mem_din_q       <= mem_din_d;
      p_ack_q         <= p_ack_d;
      d_ack_q         <= d_ack_d;
      p_rdata_q       <= p_rdata_d;
      d_rdata_q       <= d_rdata_d;
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_direccion = mem_direccion_q;
  assign mem_din       = mem_din_q;
  assign p_ack         = p_ack_q;
  assign d_ack         = d_ack_q;
  assign p_rdata       = p_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign p_stall       = p_req & ~p_ack_q;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: a round-robin instance (0) and a fixed
// priority instance (1), each with its own falling-edge memory and reference model.
module tb_arbitro_memoria_datos;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req [2], d_req [2], p_we [2], d_we [2];
  logic [9:0]  p_dir [2], d_dir [2];
  logic [31:0] p_din [2], d_din [2];
  logic        p_ack [2], d_ack [2], p_stall [2], mem_read [2], mem_write [2];
  logic [31:0] p_rdata [2], d_rdata [2], mem_din [2], mem_dout [2];
  logic [9:0]  mem_dir [2];
  logic [31:0] mem [2][1024];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arbitro_memoria_datos #(.PRIORIDAD_FIJA(0)) dut_rr (
    .clk(clk), .reset(reset),
    .p_req(p_req[0]), .p_we(p_we[0]), .p_direccion(p_dir[0]), .p_din(p_din[0]),
    .p_ack(p_ack[0]), .p_rdata(p_rdata[0]), .p_stall(p_stall[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_direccion(d_dir[0]), .d_din(d_din[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_direccion(mem_dir[0]),
    .mem_din(mem_din[0]), .mem_dout(mem_dout[0])
  );

  arbitro_memoria_datos #(.PRIORIDAD_FIJA(1)) dut_fx (
    .clk(clk), .reset(reset),
    .p_req(p_req[1]), .p_we(p_we[1]), .p_direccion(p_dir[1]), .p_din(p_din[1]),
    .p_ack(p_ack[1]), .p_rdata(p_rdata[1]), .p_stall(p_stall[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_direccion(d_dir[1]), .d_din(d_din[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_direccion(mem_dir[1]),
    .mem_din(mem_din[1]), .mem_dout(mem_dout[1])
  );

  // Single-port memories acting on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_write[i]) mem[i][mem_dir[i]] <= mem_din[i];
      if (mem_read[i])  mem_dout[i] <= mem[i][mem_dir[i]];
    end
  end

  // Reference model: a grant at edge k shows strobes one cycle later and
  // ack/rdata two cycles later; a new grant is possible three edges after k.
  int          edad [2];
  bit          m_ult [2], m_win [2], m_we [2];
  logic [31:0] m_val [2];
  logic [31:0] ref_mem [2][1024];
  logic        e_rd [2], e_wr [2], e_pack [2], e_dack [2];
  logic [9:0]  e_dir [2];
  logic [31:0] e_din [2], e_prd [2], e_drd [2];

  function automatic bit pick(input bit pr, input bit dr, input bit ult, input bit fija);
    if (pr && !dr) return 1'b0;
    if (dr && !pr) return 1'b1;
    if (fija) return 1'b0;
    return !ult;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic bit          w;
      automatic bit          we;
      automatic logic [9:0]  a;
      automatic logic [31:0] dv;
      if (reset) begin
        edad[i] <= 0; m_ult[i] <= 1'b1;
        e_rd[i] <= 1'b0; e_wr[i] <= 1'b0; e_dir[i] <= '0; e_din[i] <= '0;
        e_pack[i] <= 1'b0; e_dack[i] <= 1'b0; e_prd[i] <= '0; e_drd[i] <= '0;
      end else begin
        e_pack[i] <= 1'b0; e_dack[i] <= 1'b0; e_rd[i] <= 1'b0; e_wr[i] <= 1'b0;
        if (edad[i] == 0) begin
          if (p_req[i] || d_req[i]) begin
            w  = pick(p_req[i], d_req[i], m_ult[i], i == 1);
            we = w ? d_we[i] : p_we[i];
            a  = w ? d_dir[i] : p_dir[i];
            dv = w ? d_din[i] : p_din[i];
            m_win[i] <= w; m_ult[i] <= w; m_we[i] <= we;
            m_val[i] <= ref_mem[i][a];
            if (we) ref_mem[i][a] <= dv;
            e_rd[i] <= !we; e_wr[i] <= we; e_dir[i] <= a; e_din[i] <= dv;
            edad[i] <= 1;
          end
        end else if (edad[i] == 1) begin
          if (m_win[i]) begin
            e_dack[i] <= 1'b1;
            if (!m_we[i]) e_drd[i] <= m_val[i];
          end else begin
            e_pack[i] <= 1'b1;
            if (!m_we[i]) e_prd[i] <= m_val[i];
          end
          edad[i] <= 2;
        end else begin
          edad[i] <= 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mem_read%0d", i),  32'(mem_read[i]),  32'(e_rd[i]));
        chk($sformatf("mem_write%0d", i), 32'(mem_write[i]), 32'(e_wr[i]));
        chk($sformatf("mem_dir%0d", i),   32'(mem_dir[i]),   32'(e_dir[i]));
        chk($sformatf("mem_din%0d", i),   mem_din[i],        e_din[i]);
        chk($sformatf("p_ack%0d", i),     32'(p_ack[i]),     32'(e_pack[i]));
        chk($sformatf("d_ack%0d", i),     32'(d_ack[i]),     32'(e_dack[i]));
        chk($sformatf("p_rdata%0d", i),   p_rdata[i],        e_prd[i]);
        chk($sformatf("d_rdata%0d", i),   d_rdata[i],        e_drd[i]);
        chk($sformatf("p_stall%0d", i),   32'(p_stall[i]),   32'(p_req[i] && !e_pack[i]));
        chk($sformatf("strobe_excl%0d", i), 32'(mem_read[i] && mem_write[i]), 32'd0);
      end
    end
  end

  // Raise one request (caller sits just after a rising edge), wait for its
  // ack, then drop it just after the following rising edge.
  task automatic acceso(input int i, input bit port, input bit we, input logic [9:0] a,
                        input logic [31:0] dv, output logic [31:0] rd, output int lat);
    bit got = 1'b0;
    rd  = '0;
    lat = -1;
    if (!port) begin p_we[i] = we; p_dir[i] = a; p_din[i] = dv; p_req[i] = 1'b1; end
    else       begin d_we[i] = we; d_dir[i] = a; d_din[i] = dv; d_req[i] = 1'b1; end
    for (int n = 1; n <= 400 && !got; n++) begin
      @(negedge clk);
      if ((!port && p_ack[i]) || (port && d_ack[i])) begin
        got = 1'b1;
        lat = n;
        rd  = port ? d_rdata[i] : p_rdata[i];
      end
    end
    chk($sformatf("ack_arrived_%0d_%0d", i, port), 32'(got), 32'd1);
    @(posedge clk); #1;
    if (!port) p_req[i] = 1'b0; else d_req[i] = 1'b0;
  endtask

  function automatic logic [9:0] ra();
    if ($urandom_range(0, 3) == 0) return 10'h3FF;
    return 10'($urandom_range(0, 7));
  endfunction

  logic [31:0] rd_a, rd_b;
  int          lat_a, lat_b;

  task automatic rand_phase(input int i);
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          acceso(i, 1'b0, 1'($urandom_range(0, 1)), ra(), $urandom(), rd_a, lat_a);
        end
      end
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          acceso(i, 1'b1, 1'($urandom_range(0, 1)), ra(), $urandom(), rd_b, lat_b);
        end
      end
    join
  endtask

  int  ackq [$];
  bit  p_done;
  int  dcount, pcount;
  bit  got_d;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 1'b0; d_req[i] = 1'b0; p_we[i] = 1'b0; d_we[i] = 1'b0;
      p_dir[i] = '0; d_dir[i] = '0; p_din[i] = '0; d_din[i] = '0;
    end
    @(posedge clk);
    chk_on = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_p_rdata", p_rdata[0], 32'd0);
    chk("rst_d_ack", 32'(d_ack[0]), 32'd0);
    chk("rst_mem_read", 32'(mem_read[0]), 32'd0);
    @(posedge clk); #1;

    // Preload, single read, write then read-back.
    acceso(0, 1'b1, 1'b1, 10'h005, 32'hCAFE0001, rd_b, lat_b);
    acceso(0, 1'b0, 1'b0, 10'h005, 32'h0, rd_a, lat_a);
    chk("single_read_data", rd_a, 32'hCAFE0001);
    chk("single_read_latency", 32'(lat_a), 32'd3);
    acceso(0, 1'b1, 1'b1, 10'h3FF, 32'h12345678, rd_b, lat_b);
    chk("write_rdata_held", rd_b, 32'd0);
    chk("write_latency", 32'(lat_b), 32'd3);
    acceso(0, 1'b1, 1'b0, 10'h3FF, 32'h0, rd_b, lat_b);
    chk("readback_3ff", rd_b, 32'h12345678);

    // Back-to-back requester.
    acceso(0, 1'b0, 1'b0, 10'h3FF, 32'h0, rd_a, lat_a);
    acceso(0, 1'b0, 1'b0, 10'h005, 32'h0, rd_a, lat_a);
    chk("b2b_latency", 32'(lat_a), 32'd3);
    chk("b2b_data", rd_a, 32'hCAFE0001);

    // Reset while a d_ write is in ACCESO.
    d_we[0] = 1'b1; d_dir[0] = 10'h2A5; d_din[0] = 32'hA5A55A5A; d_req[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; d_req[0] = 1'b0;
    @(negedge clk);
    chk("rst_acceso_write", 32'(mem_write[0]), 32'd0);
    chk("rst_acceso_dack", 32'(d_ack[0]), 32'd0);
    chk("rst_acceso_committed", mem[0][10'h2A5], 32'hA5A55A5A);
    @(posedge clk); #1;
    acceso(0, 1'b1, 1'b0, 10'h2A5, 32'h0, rd_b, lat_b);
    chk("rst_acceso_readback", rd_b, 32'hA5A55A5A);
    chk("rst_acceso_idle_latency", 32'(lat_b), 32'd3);

    // Contention right after reset: p first, then alternating every 3 cycles.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    fork
      begin for (int n = 0; n < 3; n++) acceso(0, 1'b0, 1'b0, 10'h005, 32'h0, rd_a, lat_a); end
      begin for (int n = 0; n < 3; n++) acceso(0, 1'b1, 1'b0, 10'h3FF, 32'h0, rd_b, lat_b); end
      begin
        for (int n = 0; n < 25; n++) begin
          @(negedge clk);
          if (p_ack[0]) ackq.push_back(cyc * 2);
          if (d_ack[0]) ackq.push_back(cyc * 2 + 1);
        end
      end
    join
    chk("rr_ack_count", 32'(ackq.size()), 32'd6);
    if (ackq.size() >= 3) begin
      chk("rr_first_p", 32'(ackq[0] % 2), 32'd0);
      chk("rr_second_d", 32'(ackq[1] % 2), 32'd1);
      chk("rr_third_p", 32'(ackq[2] % 2), 32'd0);
      chk("rr_spacing", 32'(ackq[1] / 2 - ackq[0] / 2), 32'd3);
    end

    // Fixed priority: d_ starves while p_ keeps requesting.
    d_we[1] = 1'b0; d_dir[1] = 10'h005; d_req[1] = 1'b1;
    p_done = 1'b0; dcount = 0; pcount = 0;
    fork
      begin
        for (int n = 0; n < 4; n++)
          acceso(1, 1'b0, 1'b1, 10'(n), 32'hF0000000 + 32'(n), rd_a, lat_a);
        p_done = 1'b1;
      end
      begin
        while (!p_done) begin
          @(negedge clk);
          if (d_ack[1]) dcount++;
          if (p_ack[1]) pcount++;
        end
      end
    join
    chk("fix_d_starved", 32'(dcount), 32'd0);
    chk("fix_p_acks", 32'(pcount), 32'd4);
    got_d = 1'b0;
    for (int n = 0; n < 20 && !got_d; n++) begin
      @(negedge clk);
      if (d_ack[1]) got_d = 1'b1;
    end
    chk("fix_d_served_after", 32'(got_d), 32'd1);
    @(posedge clk); #1;
    d_req[1] = 1'b0;

    rand_phase(0);
    rand_phase(1);
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria_datos.md
# arbitro_memoria_datos

Two-requester arbiter and access sequencer for the single-port, 1024×32 data memory in the pipeline. It shares the memory between the MEM stage (port `p_`) and the debug/loader port (port `d_`). It drives the memory's read, write, address and data-in lines from registers, and returns read data through a req/ack handshake. It also raises a stall for the pipeline while a MEM-stage access is pending.

## Interface
- `ANCHO_DATOS`, 32: data width.
- `ANCHO_DIR`, 10: word-address width (1024 words).
- `PRIORIDAD_FIJA`, 0: 0 = round-robin; 1 = `p_` always wins ties.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `p_req`, `d_req` in 1: access request; held until the matching ack.
- `p_we`, `d_we` in 1: 1 = write, 0 = read; stable while req is high.
- `p_direccion`, `d_direccion` in ANCHO_DIR: word address; stable while req is high.
- `p_din`, `d_din` in ANCHO_DATOS: write data; stable while req is high.
- `p_ack`, `d_ack` out 1: one-cycle completion pulse, registered.
- `p_rdata`, `d_rdata` out ANCHO_DATOS: read result, valid while ack is high; held afterwards.
- `p_stall` out 1: `p_req & ~p_ack`, combinational.
- `mem_read`, `mem_write` out 1: memory strobes, registered.
- `mem_direccion` out ANCHO_DIR: memory address, registered.
- `mem_din` out ANCHO_DATOS: memory write data, registered.
- `mem_dout` in ANCHO_DATOS: memory read data, produced on the falling edge.

## Operation
- FSM states:
  - INACTIVO: no access in flight.
  - ACCESO: memory lines driven for exactly one cycle.
  - FIN: result captured, ack pulsed.
- INACTIVO -> ACCESO when any req is high at the rising edge.
  - Arbiter picks the winner, latches `ganador`, and loads the `mem_*` registers from the winner's port.
  - Read: `mem_read`=1, `mem_write`=0. Write: `mem_write`=1, `mem_read`=0. Never both.
- ACCESO -> FIN unconditionally.
  - Clears `mem_read` and `mem_write`.
  - On a read, captures `mem_dout` into the winner's `rdata`.
  - Pulses the winner's ack.
- FIN -> INACTIVO unconditionally.
  - Requests are ignored in FIN, so a requester deasserting on ack is never re-granted.
- Writes pulse ack; `rdata` keeps its previous value.
- Arbitration (PRIORIDAD_FIJA=0):
  - Only one req high: that port wins.
  - Both high: the port not granted last time wins.
  - Register `ultimo` updates on each grant; reset value = `d_`, so `p_` wins the first tie.
- Arbitration (PRIORIDAD_FIJA=1): `p_` wins every tie; `d_` may starve by design.
- The losing requester keeps req high and is served in the next INACTIVO.
- `mem_direccion` and `mem_din` hold their last values when idle.

## Timing
- Request sampled at edge k.
  - Memory lines valid during cycle k+1.
  - Memory acts on the falling edge inside cycle k+1.
  - `rdata` and ack valid during cycle k+2.
  - FSM back in INACTIVO at edge k+3.
- Latency: 2 cycles from the sampling edge to ack.
- Throughput: one access per 3 cycles.
- With both ports continuously requesting, grants alternate p, d, p, d at edges k, k+3, k+6, ...
- Reset values: state INACTIVO; `ultimo`=`d_`; all `mem_*`=0; both acks=0; both `rdata`=0.
- Reset is synchronous and aborts any access.
  - Strobes and acks are 0 in the cycle after the reset edge.
  - A write whose falling edge occurred before the reset edge stays committed in memory.
  - Its ack is never issued; the requester must re-request.
- Req dropped before ack: unsupported. The access still completes and the ack still pulses.

## Structure
- Shared package `pipeline_pkg`:
  - `estado_arb_t` enum (INACTIVO, ACCESO, FIN).
  - Constants ANCHO_DATOS_MEM=32 and ANCHO_DIR_MEM=10.
  - `puerto_t` encoding (P=0, D=1).
- Sub-module `arbitro_rr2`: 2-way round-robin/fixed-priority selector.
  - Inputs: the two reqs, `ultimo`, PRIORIDAD_FIJA.
  - Output: one-hot grant.
  - Combinational; the `ultimo` register stays in the parent.

## Test plan
- **Single read.** Preload word 0x05 = 32'hCAFE0001. `p_req`=1, `p_we`=0, addr 0x05 at edge k -> `mem_read`=1 in cycle k+1, `p_ack`=1 and `p_rdata`=32'hCAFE0001 in cycle k+2, `p_stall` high in cycles k..k+1.
- **Write then read-back.** `d_` writes 32'h12345678 to 0x3FF -> `d_ack` after 2 cycles, `d_rdata` unchanged. A following `d_` read of 0x3FF returns 32'h12345678.
- **Contention, round-robin.** Both reqs held after reset -> grants p at k, d at k+3, p at k+6. No cycle has `mem_read` and `mem_write` both high.
- **Fixed priority.** PRIORIDAD_FIJA=1, both reqs held for 4 accesses -> only `p_ack` pulses; `d_ack` stays 0.
- **Reset in ACCESO.** `reset`=1 while a `d_` write is in ACCESO -> all strobes and acks 0 next cycle, no `d_ack`, state INACTIVO. The write is visible at the addressed word.
- **Back-to-back requester.** `p_req` reasserted in the cycle right after `p_ack` -> next grant at the INACTIVO edge (3 cycles after the previous grant), with no duplicate ack.
